// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the round-robin serial-to-parallel
// scheduler.
//   state_e     : scheduler FSM states (IDLE, SHIFT, HOLD)
//   DEF_NCH     : default number of serial sources
//   DEF_FRAME_W : default data bits per frame
//   ch_w()      : channel tag width for a given source count (minimum 1)
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_NCH     = 4;
  localparam int DEF_FRAME_W = 4;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/s2p_rr_sched_rr_arb.sv
// rr_arb: combinational round-robin pick.
//   req_i     : per-source request vector
//   ptr_i     : index of the most recently granted source
//   win_oh_o  : one-hot winner (all zero when no request)
//   win_idx_o : binary index of the winner (0 when no request)
//   any_o     : at least one request present
// The search starts at ptr_i+1 and wraps NCH-1 -> 0, so the last winner has
// the lowest priority on the next pick.
module rr_arb
  import s2p_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int CH_W = ch_w(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [NCH-1:0]  win_oh_o,
  output logic [CH_W-1:0] win_idx_o,
  output logic            any_o
);

  always_comb begin
    logic found;
    int   c;
    found     = 1'b0;
    c         = 0;
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = |req_i;
    for (int i = 1; i <= NCH; i++) begin
      c = (int'(ptr_i) + i) % NCH;
      if (!found && req_i[c]) begin
        found        = 1'b1;
        win_oh_o[c]  = 1'b1;
        win_idx_o    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/s2p_rr_sched.sv
// s2p_rr_sched: NCH serial sources share one LSB-first deserializer.
// One source at a time is granted for a whole frame; its bits are shifted in
// and the finished word is offered with its channel tag on a valid/ready port.
//   clk, n_rst : clock (rising edge), asynchronous active-low reset
//   req        : per-source frame request (level)
//   sdata      : per-source serial bit, sampled only for the granted source
//   gnt        : registered one-hot grant
//   dout       : assembled word, bit 0 = first bit received
//   dout_ch    : source index that produced dout
//   dout_vld   : word valid, held until dout_rdy
//   dout_rdy   : consumer accept
//   busy       : FSM not in IDLE
//   perr       : even-parity error on the held word
// Build option: S2P_SCHED_PARITY_EN adds a trailing even-parity bit per frame
// (grant lasts FRAME_W+1 cycles); without it perr is tied low.
// FRAME_W is assumed >= 2.
module s2p_rr_sched
  import s2p_pkg::*;
#(
  parameter  int NCH     = DEF_NCH,
  parameter  int FRAME_W = DEF_FRAME_W,
  localparam int CH_W    = ch_w(NCH)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NCH-1:0]     req,
  input  logic [NCH-1:0]     sdata,
  output logic [NCH-1:0]     gnt,
  output logic [FRAME_W-1:0] dout,
  output logic [CH_W-1:0]    dout_ch,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               busy,
  output logic               perr
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
`ifdef S2P_SCHED_PARITY_EN
  localparam int LAST = FRAME_W;      // parity bit is the final sample
`else
  localparam int LAST = FRAME_W - 1;
`endif

  state_e             state_q, state_d;
  logic [NCH-1:0]     gnt_q;
  logic [FRAME_W-1:0] dout_q;
  logic [CH_W-1:0]    ch_q, ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               vld_q;

  logic [NCH-1:0]     win_oh;
  logic [CH_W-1:0]    win_idx;
  logic               any_req;
  logic               accept, start, shift, last;

  rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (any_req)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(LAST)) state_d = HOLD;
      HOLD:    if (dout_rdy) state_d = any_req ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode. A new frame may start straight out of HOLD on the accept
  // edge, which gives back-to-back frames with no idle cycle.
  always_comb begin
    accept = (state_q == HOLD) && dout_rdy;
    start  = any_req && ((state_q == IDLE) || accept);
    shift  = (state_q == SHIFT);
    last   = shift && (cnt_q == CNT_W'(LAST));
    busy   = (state_q != IDLE);
  end

  // Datapath: grant, shift register, tag, counter, RR pointer
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gnt_q  <= '0;
      dout_q <= '0;
      ch_q   <= '0;
      ptr_q  <= CH_W'(NCH - 1);
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else if (start) begin
      gnt_q <= win_oh;
      ch_q  <= win_idx;
      ptr_q <= win_idx;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (shift) begin
`ifdef S2P_SCHED_PARITY_EN
      // Parity bit is checked but never enters the data word
      if (cnt_q < CNT_W'(FRAME_W))
        dout_q <= {sdata[ch_q], dout_q[FRAME_W-1:1]};
`else
      dout_q <= {sdata[ch_q], dout_q[FRAME_W-1:1]};
`endif
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        gnt_q <= '0;
        vld_q <= 1'b1;
      end
    end else if (accept) begin
      vld_q <= 1'b0;
    end
  end

`ifdef S2P_SCHED_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 perr_q <= 1'b0;
    else if (start || accept)   perr_q <= 1'b0;
    else if (last)              perr_q <= (^dout_q) ^ sdata[ch_q];
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign dout     = dout_q;
  assign dout_ch  = ch_q;
  assign dout_vld = vld_q;

endmodule

// File: tb/tb_s2p_rr_sched.sv
// tb_s2p_rr_sched: directed, table-driven bench for s2p_rr_sched
// (NCH=4, FRAME_W=4). Inputs are driven and outputs sampled on the falling
// edge. Honours S2P_SCHED_PARITY_EN when defined.
module tb_s2p_rr_sched;

  localparam int NCH = 4;
  localparam int FW  = 4;
`ifdef S2P_SCHED_PARITY_EN
  localparam int NB  = FW + 1;
`else
  localparam int NB  = FW;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic [NCH-1:0] req, sdata, gnt;
  logic [FW-1:0] dout;
  logic [1:0]    dout_ch;
  logic          dout_vld, dout_rdy, busy, perr;

  int nchk = 0;
  int nerr = 0;

  s2p_rr_sched #(.NCH(NCH), .FRAME_W(FW)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req      (req),
    .sdata    (sdata),
    .gnt      (gnt),
    .dout     (dout),
    .dout_ch  (dout_ch),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy),
    .perr     (perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] data;
    logic       pbit;
    int         ch;
    logic [3:0] dout;
    logic       perr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Applies r, waits for a grant, shifts the frame in and checks the HOLD
  // outputs. Leaves the DUT in HOLD (unless dout_rdy is already high).
  task automatic do_frame(input logic [3:0] r, input logic [3:0] d, input logic pb,
                          input int ech, input logic [3:0] edout, input logic eperr,
                          input int drop_at, output int waits);
    logic [3:0] oh;
    logic       ep;
    req   = r;
    waits = 0;
    while (gnt == '0 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (gnt == '0) begin
      nchk++;
      nerr++;
      $display("FAIL grant_timeout: got no grant expected channel %0d", ech);
      return;
    end
    oh = 4'b0001 << ech;
    chk("gnt_onehot", gnt, oh);
    chk("dout_ch_at_grant", dout_ch, ech);
    for (int b = 0; b < NB; b++) begin
      if (b == drop_at) req = '0;
      sdata      = '0;
      sdata[ech] = (b < FW) ? d[b] : pb;
      chk("gnt_during_shift", gnt, oh);
      chk("vld_low_during_shift", dout_vld, 0);
      @(negedge clk);
    end
    sdata = '0;
`ifdef S2P_SCHED_PARITY_EN
    ep = eperr;
`else
    ep = 1'b0;
`endif
    chk("hold_vld", dout_vld, 1);
    chk("hold_dout", dout, edout);
    chk("hold_ch", dout_ch, ech);
    chk("hold_gnt_zero", gnt, 0);
    chk("hold_busy", busy, 1);
    chk("hold_perr", perr, ep);
  endtask

  task automatic accept_to_idle();
    req      = '0;
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
    chk("accept_vld_low", dout_vld, 0);
    chk("accept_idle", busy, 0);
    chk("accept_perr_clr", perr, 0);
  endtask

  initial begin
    int w;
    logic [3:0] held;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // req, data, parity bit, expected channel, expected dout, expected perr
    tbl[0] = '{4'b0001, 4'b1101, 1'b1, 0, 4'b1101, 1'b0};
    tbl[1] = '{4'b1001, 4'b0110, 1'b0, 3, 4'b0110, 1'b0};
    tbl[2] = '{4'b1001, 4'b1010, 1'b0, 0, 4'b1010, 1'b0};
    tbl[3] = '{4'b0110, 4'b0011, 1'b1, 1, 4'b0011, 1'b1};
    tbl[4] = '{4'b0110, 4'b1111, 1'b0, 2, 4'b1111, 1'b0};
    tbl[5] = '{4'b0110, 4'b0000, 1'b0, 1, 4'b0000, 1'b0};
    tbl[6] = '{4'b1000, 4'b1001, 1'b0, 3, 4'b1001, 1'b0};

    n_rst = 1'b0; req = '0; sdata = '0; dout_rdy = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ch", dout_ch, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", perr, 0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Table: one frame each from IDLE; pointer carries across entries
    for (int i = 0; i < 7; i++) begin
      do_frame(tbl[i].req, tbl[i].data, tbl[i].pbit, tbl[i].ch, tbl[i].dout,
               tbl[i].perr, 99, w);
      chk("tbl_grant_latency", w, 1);
      accept_to_idle();
    end

    // Back-to-back: all requesting, consumer always ready (pointer at 3)
    dout_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      held = 4'(k * 3 + 5);
      do_frame(4'b1111, held, ^held, order[k], held, 1'b0, 99, w);
      chk("b2b_no_idle_gap", w, 1);
    end
    req = '0;
    @(negedge clk);
    dout_rdy = 1'b0;
    chk("b2b_end_vld", dout_vld, 0);
    chk("b2b_end_idle", busy, 0);
    chk("idle_dout_kept", dout, 4'h1);

    // Stall in HOLD for 10 cycles with channel 1 still requesting
    do_frame(4'b0010, 4'b0101, 1'b0, 1, 4'b0101, 1'b0, 99, w);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_vld", dout_vld, 1);
      chk("stall_dout", dout, 4'b0101);
      chk("stall_gnt", gnt, 0);
    end
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
    chk("stall_regrant", gnt, 4'b0010);
    chk("stall_vld_dropped", dout_vld, 0);
    do_frame(4'b0010, 4'b1100, 1'b0, 1, 4'b1100, 1'b0, 99, w);
    chk("stall_grant_immediate", w, 0);
    accept_to_idle();

    // req of channel 3 drops after 2 bits; frame still completes
    do_frame(4'b1000, 4'b1011, 1'b1, 3, 4'b1011, 1'b0, 2, w);
    accept_to_idle();

    // Reset after 2 bits of a channel-0 frame
    req = 4'b0001;
    @(negedge clk);
    chk("mr_gnt", gnt, 4'b0001);
    sdata = 4'b0001;
    @(negedge clk);
    sdata = 4'b0000;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("mr_gnt_zero", gnt, 0);
    chk("mr_dout_zero", dout, 0);
    chk("mr_ch_zero", dout_ch, 0);
    chk("mr_vld_zero", dout_vld, 0);
    chk("mr_busy_zero", busy, 0);
    chk("mr_perr_zero", perr, 0);
    req = '0; sdata = '0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    do_frame(4'b0100, 4'b0111, 1'b1, 2, 4'b0111, 1'b0, 99, w);
    accept_to_idle();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
